// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack, decode-side valid/ready and branch redirect.
// The master modport is the fetch unit side; the slave modport is memory/decode/branch side.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: single-outstanding imem reads feeding a prefetch FIFO, with redirect flush.
// Define FETCH_STATS_EN to add saturating stat_fetched / stat_flushed counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  stat_fetched,
    output logic [31:0]  stat_flushed
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_BUSY,
        FS_DROP
    } fetchState_e;

    fetchState_e      state, stateNext;
    logic [31:0]      fetchPc, reqAddr, redirTarget;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] headPtr, tailPtr;
    logic [31:0]      fifoWord [FIFO_DEPTH];
    logic [31:0]      fifoPc   [FIFO_DEPTH];
    logic             imemReq, ackFire, push, pop, notEmpty, instrValid;
    logic [31:0]      imemAddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            FS_IDLE: if (imemReq && !bus.imem_ack) stateNext = bus.redirect ? FS_DROP : FS_BUSY;
            FS_BUSY: begin
                if (bus.imem_ack)     stateNext = FS_IDLE;
                else if (bus.redirect) stateNext = FS_DROP;
            end
            FS_DROP: if (bus.imem_ack) stateNext = FS_IDLE;
            default: stateNext = FS_IDLE;
        endcase
    end

    // Gating the idle request with rst_n keeps imem_req low for the whole reset interval.
    always_comb begin
        imemReq  = 1'b0;
        imemAddr = '0;
        unique case (state)
            FS_IDLE: begin
                if (rst_n && count < DEPTH_C) begin
                    imemReq  = 1'b1;
                    imemAddr = fetchPc;
                end
            end
            FS_BUSY, FS_DROP: begin
                imemReq  = 1'b1;
                imemAddr = reqAddr;
            end
            default: ;
        endcase
    end

    assign ackFire     = bus.imem_ack & imemReq;
    assign push        = ackFire & (state != FS_DROP) & ~bus.redirect;
    assign notEmpty    = (count != '0);
    assign instrValid  = notEmpty & ~bus.redirect;
    assign pop         = instrValid & bus.instr_ready;
    assign redirTarget = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC;
            reqAddr <= '0;
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (state == FS_IDLE && imemReq) reqAddr <= fetchPc;
            if (bus.redirect) begin
                fetchPc <= redirTarget;
                count   <= '0;
                headPtr <= '0;
                tailPtr <= '0;
            end else begin
                if (push) begin
                    fetchPc <= fetchPc + 32'd4;
                    tailPtr <= tailPtr + PTR_W'(1);
                end
                if (pop) headPtr <= headPtr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoWord[tailPtr] <= bus.imem_rdata;
            fifoPc[tailPtr]   <= imemAddr;
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = imemAddr;
    assign bus.instr_valid = instrValid;
    assign bus.instr       = notEmpty ? fifoWord[headPtr] : '0;
    assign bus.instr_pc    = notEmpty ? fifoPc[headPtr]   : '0;

`ifdef FETCH_STATS_EN
    logic        dropAck;
    logic [32:0] flushSum;

    // An ack that is not pushed is either a dropped wrong-path return or lands in the redirect cycle.
    assign dropAck  = ackFire & ~push;
    assign flushSum = {1'b0, stat_flushed} + 33'(bus.redirect ? count : '0) + 33'(dropAck);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
            stat_flushed <= flushSum[32] ? '1 : flushSum[31:0];
        end
    end
`endif
endmodule
